// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch / decode / execute sequencer that owns the
// program counter and performs all branch, jump and jr redirection.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        rs_eq_rt,
    input  logic [31:0] rs_val,
    output logic [31:0] link_addr,
    output logic [31:0] pc,
    output logic        addr_err,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {StResetWait, StFetch, StDecode, StExec} state_t;

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] FunctJr   = 6'b001000;

    state_t      state;
    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] next_pc;
    logic        jr_misaligned;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode     = instr[31:26];
    assign funct      = instr[5:0];
    assign pc_plus4   = pc + 32'd4;
    assign branch_tgt = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign link_addr  = pc_plus4;
    assign imem_addr  = pc;

    // Next-PC selection from the latched instruction and execute-time operands.
    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        unique case (opcode)
            OpBeq:     next_pc = rs_eq_rt ? branch_tgt : pc_plus4;
            OpBne:     next_pc = rs_eq_rt ? pc_plus4 : branch_tgt;
            OpJ, OpJal: next_pc = jump_tgt;
            OpSpecial: begin
                if (funct == FunctJr) begin
                    next_pc       = {rs_val[31:2], 2'b00};
                    jr_misaligned = (rs_val[1:0] != 2'b00);
                end
            end
            default:   next_pc = pc_plus4;
        endcase
    end

    // Sequencer FSM; every output is registered on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StResetWait;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            retired     <= 32'd0;
        end else begin
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            unique case (state)
                StResetWait: begin
                    state    <= StFetch;
                    imem_req <= 1'b1;
                end
                StFetch: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= StDecode;
                    end
                end
                StDecode: begin
                    state <= StExec;
                end
                StExec: begin
                    if (exec_done) begin
                        pc       <= next_pc;
                        addr_err <= jr_misaligned;
                        retired  <= retired + 32'd1;
                        imem_req <= 1'b1;
                        state    <= StFetch;
                    end
                end
                default: begin
                    state    <= StResetWait;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven program walk with a next-PC scoreboard,
// plus reset, stall, wrap-around and mid-operation reset sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        exec_done;
    logic        rs_eq_rt;
    logic [31:0] rs_val;

    logic        imem_req, instr_valid, addr_err;
    logic [31:0] imem_addr, instr, link_addr, pc, retired;

    logic        w_imem_req, w_instr_valid, w_addr_err;
    logic [31:0] w_imem_addr, w_instr, w_link_addr, w_pc, w_retired;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .rs_eq_rt(rs_eq_rt),
        .rs_val(rs_val), .link_addr(link_addr), .pc(pc), .addr_err(addr_err),
        .retired(retired)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(w_instr),
        .instr_valid(w_instr_valid), .exec_done(exec_done), .rs_eq_rt(rs_eq_rt),
        .rs_val(rs_val), .link_addr(w_link_addr), .pc(w_pc), .addr_err(w_addr_err),
        .retired(w_retired)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        eq;
        logic [31:0] rsv;
        logic [31:0] nxt;
        logic        aerr;
        int          rdly;
        int          ddly;
    } vec_t;

    localparam int NumVec = 16;

    vec_t        tbl [NumVec];
    logic [31:0] sb_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_fetch = -1;
    int          exp_retired = 0;
    bit          first_pass = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] p, input logic [31:0] w,
                           input logic e, input logic [31:0] r, input logic [31:0] n,
                           input logic a, input int rd, input int dd);
        tbl[i].pc = p;  tbl[i].word = w;  tbl[i].eq = e;   tbl[i].rsv = r;
        tbl[i].nxt = n; tbl[i].aerr = a;  tbl[i].rdly = rd; tbl[i].ddly = dd;
    endtask

    // Fetch and decode phases of one table entry; returns at a negedge in EXEC.
    task automatic do_fetch(input int i, input bit prev_fast);
        int          n;
        logic [31:0] start_addr;
        logic [31:0] exp_pc;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("fetch_req_seen[%0d]", i), {31'd0, imem_req}, 32'd1);
        if (sb_q.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", i), 32'd0, 32'd1);
            exp_pc = tbl[i].pc;
        end else begin
            exp_pc = sb_q.pop_front();
        end
        chk($sformatf("imem_addr[%0d]", i), imem_addr, exp_pc);
        chk($sformatf("pc_table[%0d]", i), pc, tbl[i].pc);
        if (prev_fast && last_fetch >= 0)
            chk($sformatf("period[%0d]", i), cyc - last_fetch, 32'd3);
        last_fetch = cyc;
        start_addr = imem_addr;
        for (int k = 0; k < tbl[i].rdly; k++) begin
            chk($sformatf("stall_req[%0d]", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("stall_addr[%0d]", i), imem_addr, start_addr);
            chk($sformatf("stall_ivalid[%0d]", i), {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        imem_ready = 1'b1;
        imem_rdata = tbl[i].word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk($sformatf("decode_ivalid[%0d]", i), {31'd0, instr_valid}, 32'd1);
        chk($sformatf("decode_instr[%0d]", i), instr, tbl[i].word);
        chk($sformatf("decode_req[%0d]", i), {31'd0, imem_req}, 32'd0);
        chk($sformatf("addr_err_low[%0d]", i), {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        chk($sformatf("exec_ivalid[%0d]", i), {31'd0, instr_valid}, 32'd0);
        chk($sformatf("exec_instr[%0d]", i), instr, tbl[i].word);
    endtask

    // Execute phase: optional wait, then exec_done with the entry's operands.
    task automatic do_exec(input int i);
        for (int k = 0; k < tbl[i].ddly; k++) begin
            chk($sformatf("exec_wait_retired[%0d]", i), retired, exp_retired);
            @(negedge clk);
        end
        chk($sformatf("link_addr[%0d]", i), link_addr, tbl[i].pc + 32'd4);
        if (first_pass && i == 0) begin
            chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
            chk("wrap_link_addr", w_link_addr, 32'd0);
        end
        exec_done = 1'b1;
        rs_eq_rt  = tbl[i].eq;
        rs_val    = tbl[i].rsv;
        sb_q.push_back(tbl[i].nxt);
        @(negedge clk);
        exec_done = 1'b0;
        rs_eq_rt  = 1'b0;
        rs_val    = 32'd0;
        exp_retired++;
        chk($sformatf("addr_err[%0d]", i), {31'd0, addr_err}, {31'd0, tbl[i].aerr});
        chk($sformatf("retired[%0d]", i), retired, exp_retired);
        if (first_pass && i == 0) chk("wrap_next_pc", w_pc, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //      idx pc            word          eq rs_val        next          ae rd dd
        set_vec(0,  32'h0040_0000, 32'h0000_0000, 0, 32'h0,        32'h0040_0004, 0, 0, 0);
        set_vec(1,  32'h0040_0004, 32'h0000_0000, 0, 32'h0,        32'h0040_0008, 0, 0, 0);
        set_vec(2,  32'h0040_0008, 32'h0000_0000, 0, 32'h0,        32'h0040_000C, 0, 0, 0);
        set_vec(3,  32'h0040_000C, 32'h0000_0000, 0, 32'h0,        32'h0040_0010, 0, 0, 2);
        set_vec(4,  32'h0040_0010, 32'h1022_FFFF, 1, 32'h0,        32'h0040_0010, 0, 0, 0);
        set_vec(5,  32'h0040_0010, 32'h1422_000C, 1, 32'h0,        32'h0040_0014, 0, 1, 0);
        set_vec(6,  32'h0040_0014, 32'h1422_FFFE, 0, 32'h0,        32'h0040_0010, 0, 0, 0);
        set_vec(7,  32'h0040_0010, 32'h1022_0004, 1, 32'h0,        32'h0040_0024, 0, 0, 0);
        set_vec(8,  32'h0040_0024, 32'h1022_0004, 0, 32'h0,        32'h0040_0028, 0, 5, 0);
        set_vec(9,  32'h0040_0028, 32'h1022_FFFD, 1, 32'h0,        32'h0040_0020, 0, 0, 0);
        set_vec(10, 32'h0040_0020, 32'h0C10_0000, 0, 32'h0,        32'h0040_0000, 0, 0, 0);
        set_vec(11, 32'h0040_0000, 32'h0020_0008, 0, 32'h0040_0102, 32'h0040_0100, 1, 0, 0);
        set_vec(12, 32'h0040_0100, 32'h0020_0008, 0, 32'h0040_0200, 32'h0040_0200, 0, 0, 1);
        set_vec(13, 32'h0040_0200, 32'h0BFF_FFFF, 0, 32'h0,        32'h0FFF_FFFC, 0, 0, 0);
        set_vec(14, 32'h0FFF_FFFC, 32'h0800_0010, 0, 32'h0,        32'h1000_0040, 0, 0, 0);
        set_vec(15, 32'h1000_0040, 32'hFC00_0000, 1, 32'h0,        32'h1000_0044, 0, 0, 0);

        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
        exec_done = 1'b0; rs_eq_rt = 1'b0; rs_val = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_instr", instr, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_wait_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        sb_q.push_back(32'h0040_0000);

        // First pass stops in the EXEC of entry 7 for a mid-operation reset.
        for (int i = 0; i < 7; i++) begin
            do_fetch(i, (i > 0) && tbl[i-1].rdly == 0 && tbl[i-1].ddly == 0);
            do_exec(i);
        end
        do_fetch(7, 1'b1);
        chk("pre_reset_retired", retired, 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0040_0000);
        chk("mid_rst_retired", retired, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        exec_done = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_wait_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("mid_rel_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("mid_rel_retired", retired, 32'd0);
        @(negedge clk);
        chk("mid_rel_retired2", retired, 32'd0);
        chk("mid_rel_addr", imem_addr, 32'h0040_0000);
        exec_done = 1'b0;

        first_pass = 1'b0;
        sb_q.delete();
        sb_q.push_back(32'h0040_0000);
        exp_retired = 0;
        last_fetch = -1;
        for (int i = 0; i < NumVec; i++) begin
            do_fetch(i, (i > 0) && tbl[i-1].rdly == 0 && tbl[i-1].ddly == 0);
            do_exec(i);
        end
        chk("final_fetch_addr", imem_addr, sb_q.size() > 0 ? sb_q[0] : 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
